// File: rtl/axi2iob_pkg.sv
// rtl/axi2iob_pkg.sv - shared AXI field widths, encodings and FSM states for the axi2iob bridge
package axi2iob_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_DATA
    } state_t;

    // Only full-width beats can be mapped onto the native port.
    function automatic logic size_mismatch(input logic [AXI_SIZE_W-1:0] size, input int data_w);
        return 32'(size) != 32'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi2iob_addr_gen.sv
// rtl/axi2iob_addr_gen.sv - latched burst address with per-beat advance and size-error flag
module axi2iob_addr_gen
    import axi2iob_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int DATA_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [AXI_ADDR_W-1:0]  load_addr,
    input  logic [AXI_SIZE_W-1:0]  load_size,
    input  logic [AXI_BURST_W-1:0] load_burst,
    input  logic                   advance,
    output logic [AXI_ADDR_W-1:0]  addr,
    output logic                   size_err
);

    logic [AXI_SIZE_W-1:0]  size_q;
    logic [AXI_BURST_W-1:0] burst_q;

    // WRAP bursts fall through to the INCR path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            size_q  <= AXI_SIZE_W'($clog2(DATA_W / 8));
            burst_q <= BURST_INCR;
        end else if (load) begin
            addr    <= load_addr;
            size_q  <= load_size;
            burst_q <= load_burst;
        end else if (advance && burst_q != BURST_FIXED) begin
            addr <= addr + (AXI_ADDR_W'(1) << size_q);
        end
    end

    // Look through to the incoming size on the load cycle so the first beat decision is immediate.
    assign size_err = size_mismatch(load ? load_size : size_q, DATA_W);

endmodule

// File: rtl/axi2iob.sv
// rtl/axi2iob.sv - AXI4 slave that replays read/write bursts as single-beat native accesses
module axi2iob
    import axi2iob_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = ADDR_W,
    parameter int AXI_DATA_W = DATA_W,
    parameter int AXI_ID_W   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [AXI_LEN_W-1:0]    s_axi_awlen,
    input  logic [AXI_SIZE_W-1:0]   s_axi_awsize,
    input  logic [AXI_BURST_W-1:0]  s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [AXI_RESP_W-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [AXI_LEN_W-1:0]    s_axi_arlen,
    input  logic [AXI_SIZE_W-1:0]   s_axi_arsize,
    input  logic [AXI_BURST_W-1:0]  s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [AXI_RESP_W-1:0]   s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    m_valid,
    output logic [ADDR_W-1:0]       m_addr,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W/8-1:0]     m_wstrb,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic                    m_ready
);

    state_t                 state, state_nxt;
    logic [AXI_ID_W-1:0]    id_q;
    logic [AXI_LEN_W-1:0]   len_q, cnt_q;
    logic                   last_wr_q, last_beat_q;
    logic [AXI_ADDR_W-1:0]  beat_addr;
    logic                   size_err;
    logic aw_win, ar_win, aw_hs, ar_hs, w_hs, m_hs, r_hs, w_last_now;

    // Fair alternation under contention: the direction not served last wins.
    assign aw_win     = s_axi_awvalid && (!s_axi_arvalid || !last_wr_q);
    assign ar_win     = s_axi_arvalid && !aw_win;
    assign aw_hs      = (state == ST_IDLE) && aw_win;
    assign ar_hs      = (state == ST_IDLE) && ar_win;
    assign w_hs       = (state == ST_WR_DATA) && !m_valid && s_axi_wvalid;
    assign m_hs       = m_valid && m_ready;
    assign r_hs       = s_axi_rvalid && s_axi_rready;
    assign w_last_now = s_axi_wlast || (cnt_q == len_q);

    axi2iob_addr_gen #(
        .AXI_ADDR_W (AXI_ADDR_W),
        .DATA_W     (DATA_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (aw_hs || ar_hs),
        .load_addr  (aw_hs ? s_axi_awaddr  : s_axi_araddr),
        .load_size  (aw_hs ? s_axi_awsize  : s_axi_arsize),
        .load_burst (aw_hs ? s_axi_awburst : s_axi_arburst),
        .advance    (m_hs),
        .addr       (beat_addr),
        .size_err   (size_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axi_awready = aw_win;
                s_axi_arready = ar_win;
                if (aw_win)      state_nxt = ST_WR_DATA;
                else if (ar_win) state_nxt = ST_RD_DATA;
            end
            ST_WR_DATA: begin
                s_axi_wready = !m_valid;
                if (w_hs && size_err && w_last_now) state_nxt = ST_WR_RESP;
                else if (m_hs && last_beat_q)       state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_nxt = ST_IDLE;
            end
            ST_RD_DATA: begin
                if (r_hs && s_axi_rlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshakes below are mutually exclusive by construction, so their order does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q         <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            last_wr_q    <= 1'b0;
            last_beat_q  <= 1'b0;
            m_valid      <= 1'b0;
            m_wdata      <= '0;
            m_wstrb      <= '0;
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            if (aw_hs || ar_hs) begin
                id_q      <= aw_hs ? s_axi_awid : s_axi_arid;
                len_q     <= aw_hs ? s_axi_awlen : s_axi_arlen;
                cnt_q     <= '0;
                last_wr_q <= aw_hs;
            end
            if (ar_hs) begin
                m_wstrb <= '0;
                if (size_err) begin
                    s_axi_rvalid <= 1'b1;
                    s_axi_rlast  <= (s_axi_arlen == '0);
                    s_axi_rdata  <= '0;
                end else begin
                    m_valid <= 1'b1;
                end
            end
            if (w_hs) begin
                last_beat_q <= w_last_now;
                if (!w_last_now) cnt_q <= cnt_q + 1'b1;
                if (!size_err) begin
                    m_valid <= 1'b1;
                    m_wdata <= s_axi_wdata;
                    m_wstrb <= s_axi_wstrb;
                end
            end
            if (m_hs) begin
                m_valid <= 1'b0;
                if (state == ST_RD_DATA) begin
                    s_axi_rvalid <= 1'b1;
                    s_axi_rdata  <= m_rdata;
                    s_axi_rlast  <= (cnt_q == len_q);
                end
            end
            if (r_hs) begin
                s_axi_rvalid <= 1'b0;
                s_axi_rlast  <= 1'b0;
                if (!s_axi_rlast) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (size_err) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= '0;
                        s_axi_rlast  <= (AXI_LEN_W'(cnt_q + 1'b1) == len_q);
                    end else begin
                        m_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign m_addr      = beat_addr[ADDR_W-1:0];
    assign s_axi_bid   = id_q;
    assign s_axi_rid   = id_q;
    assign s_axi_bresp = (s_axi_bvalid && size_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rresp = (s_axi_rvalid && size_err) ? RESP_SLVERR : RESP_OKAY;

endmodule
